alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one 32-bit integer ALU between NUM_REQ requesters (e.g. the execute-stage
//  datapath and a multi-cycle address/branch-target unit) using round-robin arbitration.
//  Each requester has a valid/ready request channel and a valid/ready response channel.
//  Sits in the execute stage, wrapping a single alu instance. Throughput is 1 op/cycle.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  NUM_REQ     2   number of requesters; supported range 2..4
// PORTS
//  clk          in   1                     clock, rising edge
//  rst_n        in   1                     asynchronous reset, active low
//  ReqValid     in   NUM_REQ               per-requester request valid
//  ReqReady     out  NUM_REQ               per-requester request accepted this cycle
//  ReqSrcA      in   NUM_REQ*DATA_WIDTH    operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  ReqSrcB      in   NUM_REQ*DATA_WIDTH    operand B, same packing as ReqSrcA
//  ReqALUCtrl   in   NUM_REQ*4             ALU op code, requester i at [i*4 +: 4]
//  RespValid    out  NUM_REQ               one-hot; result available for requester i
//  RespReady    in   NUM_REQ               requester i consumes the result
//  RespId       out  $clog2(NUM_REQ)       index of the current result owner
//  ALUResult    out  DATA_WIDTH            result, valid while any RespValid bit is high
//  Zero         out  1                     ALUResult == 0, same validity as ALUResult
// BEHAVIOUR
//  - Reset (rst_n=0, async): ReqReady=0, RespValid=0, RespId=0, operand regs=0,
//    ALUResult=0, Zero=1; rr pointer=0; state=IDLE. No response survives reset.
//  - States: IDLE (no held result), HOLD (result held for RespId).
//  - Slot free: IDLE, or HOLD with RespReady[RespId]=1 in the same cycle.
//  - Grant: when slot free, winner = first i with ReqValid[i]=1 scanning from the rr
//    pointer upward with wrap-around; ReqReady is combinational, one-hot, and asserted
//    only for the winner. ReqReady is 0 for all requesters when the slot is not free.
//  - Accept edge: operands, op code and owner id are registered; state->HOLD;
//    rr pointer <- (winner+1) mod NUM_REQ.
//  - Latency: result is visible the cycle after accept. ALUResult and Zero come
//    combinationally from the registered operands, so they are stable while in HOLD.
//  - RespValid[RespId]=1 throughout HOLD, until RespReady[RespId]=1. RespReady bits of
//    non-owners are ignored.
//  - Response and new request in the same cycle: the response completes and the new op
//    is accepted on the same edge, giving back-to-back results with no bubble.
//    With no new request on that edge: HOLD->IDLE.
//  - Request inputs need not be held stable before grant; the sampled value is used.
//    Deasserting ReqValid before ReqReady is legal; the request is then simply dropped.
//  - ALU op codes:
//      0000 add   0001 sub   0010 and   0011 or   0100 xor
//      0101 sll   0110 sra   0111 srl   1000 slt  1001 sltu
//    Shift amount is SrcB[4:0]. Add/sub wrap modulo 2^DATA_WIDTH.
//    Codes 1010-1111 give ALUResult=0 and Zero=1; no error is flagged.
//  - Reset asserted mid-HOLD: the result is discarded and no RespValid appears after
//    release; the first post-reset grant goes to the lowest valid index.
// STRUCTURE
//  - Shared package alu_pkg: alu_op_e enum (the 4-bit codes above), ALU_OP_W=4,
//    and localparam REQ_ID_W=$clog2(NUM_REQ).
//  - One sub-module: alu (combinational, DATA_WIDTH param), fed from the operand regs.
//  - Local logic: rr_pick function (rotate, priority-encode, un-rotate), a 1-bit state
//    register, and the operand/op/owner registers.
// TESTING
//  1. Single op: req0 A=5, B=3, op=0000 -> ReqReady[0] in same cycle; next cycle
//     RespValid=01, ALUResult=8, Zero=0.
//  2. Contention: both valid for 4 cycles with RespReady=11 -> grants 0,1,0,1,
//     one result per cycle, RespId alternates.
//  3. Backpressure: req1 op sub A=7, B=7, RespReady[1]=0 for 3 cycles -> RespValid=10
//     held, ALUResult=0, Zero=1; ReqReady=00 throughout; req0 is granted on the
//     release cycle.
//  4. Ops: sra A=0x8000_0000, B=4 -> 0xF800_0000; sltu A=1, B=0xFFFF_FFFF -> 1;
//     slt same operands -> 0; illegal op 1111 -> ALUResult=0, Zero=1.
//  5. Reset mid-HOLD: assert rst_n=0 while RespValid=01 -> outputs go to reset values
//     asynchronously; after release there is no stale RespValid and req0 wins first.
//  6. Withdrawn request: ReqValid[1] pulses for one cycle while the slot is busy ->
//     never granted, no response issued.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: ALU op codes, FSM states and widths.
package alu_pkg;

  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned REQ_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; unknown op codes yield zero.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [ALU_OP_W-1:0]   op,
  output logic [DATA_WIDTH-1:0] result_c,
  output logic                  zero_c
);

  logic [4:0] shamt;

  assign shamt = src_b[4:0];

  always_comb begin
    result_c = '0;
    case (alu_op_e'(op))
      OP_ADD:  result_c = src_a + src_b;
      OP_SUB:  result_c = src_a - src_b;
      OP_AND:  result_c = src_a & src_b;
      OP_OR:   result_c = src_a | src_b;
      OP_XOR:  result_c = src_a ^ src_b;
      OP_SLL:  result_c = src_a << shamt;
      OP_SRA:  result_c = $unsigned($signed(src_a) >>> shamt);
      OP_SRL:  result_c = src_a >> shamt;
      OP_SLT:  result_c = DATA_WIDTH'($signed(src_a) < $signed(src_b));
      OP_SLTU: result_c = DATA_WIDTH'(src_a < src_b);
      default: result_c = '0;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a one-deep result slot.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            ReqValid,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqSrcA,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqSrcB,
  input  logic [NUM_REQ*ALU_OP_W-1:0]   ReqALUCtrl,
  output logic [NUM_REQ-1:0]            RespValid,
  input  logic [NUM_REQ-1:0]            RespReady,
  output logic [$clog2(NUM_REQ)-1:0]    RespId,
  output logic [DATA_WIDTH-1:0]         ALUResult,
  output logic                          Zero
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       owner_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, sel_a, sel_b;
  logic [ALU_OP_W-1:0]   op_q, sel_op;
  logic [ID_W:0]         pick;
  logic [ID_W-1:0]       win;
  logic                  slot_free, do_accept;

  // Rotate requests so the pointer sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [ID_W-1:0]    ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int unsigned          pos;
    int unsigned          sum;
    dbl = {valid, valid} >> ptr;
    rot = dbl[NUM_REQ-1:0];
    pos = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pos = unsigned'(i);
    end
    sum = pos + 32'(ptr);
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return {|rot, ID_W'(sum)};
  endfunction

  // Next state, grant and operand selection.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_a     = '0;
    sel_b     = '0;
    sel_op    = '0;
    ReqReady  = '0;
    pick      = rr_pick(ReqValid, ptr_q);
    win       = pick[ID_W-1:0];
    slot_free = rst_n && ((state_q == ST_IDLE) || RespReady[owner_q]);
    do_accept = slot_free && pick[ID_W];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == ID_W'(i)) begin
        sel_a  = ReqSrcA[i*DATA_WIDTH +: DATA_WIDTH];
        sel_b  = ReqSrcB[i*DATA_WIDTH +: DATA_WIDTH];
        sel_op = ReqALUCtrl[i*ALU_OP_W +: ALU_OP_W];
      end
      ReqReady[i] = do_accept && (win == ID_W'(i));
    end
    if (do_accept) begin
      state_d = ST_HOLD;
      ptr_d   = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end else if (slot_free) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (do_accept) begin
        owner_q <= win;
        a_q     <= sel_a;
        b_q     <= sel_b;
        op_q    <= sel_op;
      end
    end
  end

  always_comb begin
    RespValid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      RespValid[i] = (state_q == ST_HOLD) && (owner_q == ID_W'(i));
    end
  end

  assign RespId = owner_q;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .src_a    (a_q),
    .src_b    (b_q),
    .op       (op_q),
    .result_c (ALUResult),
    .zero_c   (Zero)
  );

endmodule
